fp_div_sched: RTL and testbench
===============================

FP_DIV_SCHED -- requirements
Module: fp_div_sched

Interface
REQ-001 Parameter DIV_WIDTH, default 55: operand, quotient and remainder width of the shared divider core.
REQ-002 Parameter ID_WIDTH, default 4: requester tag width.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 reqN_valid  in  1  request N (N=0,1) presents an operation.
REQ-006 reqN_ready  out  1  request N accepted this cycle when valid and ready are both high.
REQ-007 reqN_dividend, reqN_divisor  in  DIV_WIDTH each  operands of request N.
REQ-008 reqN_id  in  ID_WIDTH  tag of request N.
REQ-009 core_start  out  1  single-cycle launch pulse to the divider core.
REQ-010 core_dividend, core_divisor  out  DIV_WIDTH each  core operands, valid with core_start.
REQ-011 core_done  in  1  single-cycle completion pulse from the core.
REQ-012 core_quotient, core_remainder  in  DIV_WIDTH each  core results, valid with core_done.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_quotient, out_remainder  out  DIV_WIDTH each; out_id  out  ID_WIDTH; out_port  out  1  originating requester.

Function
REQ-016 FSM states SHALL be IDLE, BUSY, HOLD.
REQ-017 IDLE: reqN_ready SHALL be high only for the arbitration winner; on handshake, operands, id and port SHALL be registered and the FSM SHALL enter BUSY.
REQ-018 core_start SHALL pulse for exactly one cycle, the cycle after the accepting handshake, with registered operands on core_dividend/core_divisor.
REQ-019 core_dividend/core_divisor SHALL hold stable from core_start until core_done.
REQ-020 BUSY: both reqN_ready SHALL be low; on core_done, quotient and remainder SHALL be captured and the FSM SHALL enter HOLD.
REQ-021 HOLD: out_valid SHALL be high, and out_quotient, out_remainder, out_id and out_port SHALL be stable until out_ready.
REQ-022 HOLD with out_ready: result retired; if a request is valid in the same cycle, it SHALL be accepted (reqN_ready high) and the FSM SHALL go to BUSY; otherwise the FSM SHALL go to IDLE. Back-to-back issue is required, with no idle bubble.
REQ-023 Latency from accepting handshake to out_valid SHALL be the core latency plus 2 cycles.
REQ-024 Arbitration with both requests valid: see Configuration. A single valid request SHALL always win.
REQ-025 core_done outside BUSY SHALL be ignored, and a sticky internal error flag SHALL be set, checked by assertion.
REQ-026 out_valid SHALL never rise without a preceding core_done; at most one operation SHALL be in flight.
REQ-027 Requester inputs SHALL be sampled only on their handshake cycle; changes while not ready SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE, with core_start=0, out_valid=0, reqN_ready=0 during reset, out data/id/port=0, round-robin pointer=0 (port 0 favoured) and error flag cleared.
REQ-029 rst mid-operation SHALL abandon the in-flight result; a core_done arriving after reset SHALL be discarded without setting the error flag.

Configuration
REQ-030 Macro FP_DIV_SCHED_RR_EN defined: round-robin arbitration; after a grant to port N, port 1-N SHALL have priority on the next conflict.
REQ-031 Macro FP_DIV_SCHED_RR_EN undefined: fixed priority, with port 0 always winning a conflict and no pointer register instantiated.

Verification
REQ-032 Single op: req0 dividend=0x0C0..0, divisor=0x080..0, id=3 -> one core_start, out_valid after core latency+2, out_id=3, out_port=0, quotient=core_quotient.
REQ-033 Conflict, with RR_EN: both valid continuously for 4 ops -> grant order 0,1,0,1; without RR_EN -> 0,0,0,0 with req1 starved.
REQ-034 Backpressure: out_ready low 10 cycles in HOLD -> outputs stable, reqN_ready=0, no core_start; out_ready high with req1 valid -> same-cycle accept, core_start next cycle.
REQ-035 Reset mid-BUSY: rst asserted 3 cycles after core_start -> IDLE, out_valid=0; the subsequent stale core_done produces no output.
REQ-036 Spurious core_done in IDLE -> no out_valid, error flag set, assertion fires.
REQ-037 Operand hold: toggle req0_dividend while req0_ready=0 -> captured value equals the value at the handshake cycle.

Source files
------------

// File: rtl/fp_div_sched.sv
// Two-requester scheduler for one shared multi-cycle divider core, one operation in flight.
// Build option: define FP_DIV_SCHED_RR_EN for round-robin arbitration (default is fixed priority, port 0 wins).
module fp_div_sched #(
  parameter int DIV_WIDTH = 55,
  parameter int ID_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [DIV_WIDTH-1:0] req0_dividend,
  input  logic [DIV_WIDTH-1:0] req0_divisor,
  input  logic [ID_WIDTH-1:0]  req0_id,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [DIV_WIDTH-1:0] req1_dividend,
  input  logic [DIV_WIDTH-1:0] req1_divisor,
  input  logic [ID_WIDTH-1:0]  req1_id,
  output logic                 core_start,
  output logic [DIV_WIDTH-1:0] core_dividend,
  output logic [DIV_WIDTH-1:0] core_divisor,
  input  logic                 core_done,
  input  logic [DIV_WIDTH-1:0] core_quotient,
  input  logic [DIV_WIDTH-1:0] core_remainder,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIV_WIDTH-1:0] out_quotient,
  output logic [DIV_WIDTH-1:0] out_remainder,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic                 out_port,
  output logic [1:0]           dbg_state_o,
  output logic                 dbg_err_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // ready never depends on anything registered later than the current cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] dividend_q, divisor_q, quot_q, rem_q;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 port_q, start_q, err_q, stale_q;
  logic                 prio1, grant0, grant1, accept_en, accept, take_done;

`ifdef FP_DIV_SCHED_RR_EN
  logic rr_q;
  assign prio1 = rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~grant1;
    end
  end
`else
  assign prio1 = 1'b0;
`endif

  assign grant1    = req1_valid && (!req0_valid || prio1);
  assign grant0    = req0_valid && !grant1;
  assign accept_en = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign req0_ready = accept_en && grant0;
  assign req1_ready = accept_en && grant1;
  assign accept     = req0_ready || req1_ready;
  // A completion owed to an operation abandoned by reset is swallowed, never delivered.
  assign take_done  = (state_q == BUSY) && core_done && !stale_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (take_done) state_d = HOLD;
      HOLD:    if (out_ready) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      id_q       <= '0;
      port_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      // Only a launched operation (start already seen by the core) leaves a completion pending.
      stale_q    <= (stale_q || ((state_q == BUSY) && !start_q)) && !core_done;
    end else begin
      state_q <= state_d;
      start_q <= accept;
      if (accept) begin
        dividend_q <= grant1 ? req1_dividend : req0_dividend;
        divisor_q  <= grant1 ? req1_divisor  : req0_divisor;
        id_q       <= grant1 ? req1_id       : req0_id;
        port_q     <= grant1;
      end
      if (take_done) begin
        quot_q <= core_quotient;
        rem_q  <= core_remainder;
      end
      if (core_done && stale_q) begin
        stale_q <= 1'b0;
      end
      if (core_done && (state_q != BUSY) && !stale_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign core_start    = start_q && !rst;
  assign core_dividend = dividend_q;
  assign core_divisor  = divisor_q;
  assign out_valid     = (state_q == HOLD) && !rst;
  assign out_quotient  = quot_q;
  assign out_remainder = rem_q;
  assign out_id        = id_q;
  assign out_port      = port_q;
  assign dbg_state_o   = state_q;
  assign dbg_err_o     = err_q;

  a_err_on_stray_done: assert property (@(posedge clk) disable iff (rst)
    (core_done && (state_q != BUSY) && !stale_q) |=> err_q);
  a_start_only_busy: assert property (@(posedge clk) disable iff (rst)
    core_start |-> (state_q == BUSY));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(quot_q) && $stable(rem_q)
                                   && $stable(id_q) && $stable(port_q)));

endmodule

// File: tb/tb_fp_div_sched.sv
// Self-checking bench for fp_div_sched: behavioural divider core, handshake monitor and result scoreboard.
module tb_fp_div_sched;
  localparam int DW = 55;
  localparam int IW = 4;
  localparam int CORE_LAT = 6;
  localparam int EW = 1 + IW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic [IW-1:0] req0_id, req1_id;
  logic          core_start, core_done, model_done = 1'b0, spur_done;
  logic [DW-1:0] core_dividend, core_divisor;
  logic [DW-1:0] core_quotient = '0, core_remainder = '0;
  logic          out_valid, out_ready, out_port;
  logic [DW-1:0] out_quotient, out_remainder;
  logic [IW-1:0] out_id;
  logic [1:0]    dbg_state_o;
  logic          dbg_err_o;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int lat_q[$];
  int grant_q[$];
  int cyc = 0, hs_cnt = 0, out_cnt = 0, start_cnt = 0, done_cnt = 0, ov_cnt = 0;
  int last_hs_cyc = 0, last_start_cyc = 0;
  logic [DW-1:0] start_div = '0;
  logic prev_ov = 1'b0;

  assign core_done = model_done | spur_done;

  always #5 clk = ~clk;

  fp_div_sched #(.DIV_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dividend(req0_dividend),
    .req0_divisor(req0_divisor), .req0_id(req0_id),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dividend(req1_dividend),
    .req1_divisor(req1_divisor), .req1_id(req1_id),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
    .out_remainder(out_remainder), .out_id(out_id), .out_port(out_port),
    .dbg_state_o(dbg_state_o), .dbg_err_o(dbg_err_o)
  );

  // Divider core: done pulses CORE_LAT cycles after the start cycle; it ignores scheduler reset.
  int core_cnt = 0;
  logic [DW-1:0] m_a = '0, m_b = '1;
  always @(negedge clk) begin
    model_done = 1'b0;
    if (core_start) begin
      m_a = core_dividend;
      m_b = core_divisor;
      core_cnt = CORE_LAT;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        model_done = 1'b1;
        core_quotient = m_a / m_b;
        core_remainder = m_a % m_b;
      end
    end
  end

  function automatic logic [DW-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_div();
    logic [DW-1:0] d;
    d = rnd_op() >> $urandom_range(8, 40);
    return d | 1;
  endfunction

  // One clock cycle: sample just before the rising edge, then return 1 time unit after it.
  task automatic tick();
    logic [EW-1:0] got, exp;
    @(negedge clk);
    #4;
    cyc++;
    if (req0_valid && req0_ready) begin
      exp_q.push_back({1'b0, req0_id, req0_dividend / req0_divisor, req0_dividend % req0_divisor});
      lat_q.push_back(cyc);
      grant_q.push_back(0);
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (req1_valid && req1_ready) begin
      exp_q.push_back({1'b1, req1_id, req1_dividend / req1_divisor, req1_dividend % req1_divisor});
      lat_q.push_back(cyc);
      grant_q.push_back(1);
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (core_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      start_div = core_dividend;
    end
    if (core_done) done_cnt++;
    if (out_valid) ov_cnt++;
    if (out_valid && !prev_ov) begin
      checks++;
      if (lat_q.size() == 0) begin
        failures++;
        $display("FAIL latency: out_valid rose at cycle %0d with no accepted request", cyc);
      end else begin
        int t;
        t = lat_q.pop_front();
        if (cyc - t != CORE_LAT + 2) begin
          failures++;
          $display("FAIL latency: got %0d cycles, required %0d", cyc - t, CORE_LAT + 2);
        end
      end
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      checks++;
      got = {out_port, out_id, out_quotient, out_remainder};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: result %h delivered with nothing expected", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL scoreboard: got %h required %h", got, exp);
        end
      end
    end
    prev_ov = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    prev_ov = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (hs_cnt < target) begin
      failures++;
      $display("FAIL handshake_timeout: got %0d handshakes, required %0d", hs_cnt, target);
    end
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 120) begin
      tick();
      n++;
    end
    checks++;
    if (out_cnt < target) begin
      failures++;
      $display("FAIL result_timeout: got %0d results, required %0d", out_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, core_start, out_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000", {req0_ready, req1_ready, core_start, out_valid});
    end
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({dbg_state_o, dbg_err_o, out_port, out_id, out_quotient, out_remainder} !== '0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d err=%b port=%b id=%h q=%h r=%h required all zero",
               dbg_state_o, dbg_err_o, out_port, out_id, out_quotient, out_remainder);
    end
  endtask

  task automatic test_single_op();
    int s0, h0, o0;
    s0 = start_cnt;
    h0 = hs_cnt;
    o0 = out_cnt;
    req0_dividend = 55'h0C000000000000;
    req0_divisor = 55'h08000000000000;
    req0_id = 4'd3;
    req0_valid = 1'b1;
    out_ready = 1'b1;
    wait_hs(h0 + 1);
    req0_valid = 1'b0;
    wait_out(o0 + 1);
    checks++;
    if (start_cnt - s0 != 1) begin
      failures++;
      $display("FAIL single_start_count: got %0d required 1", start_cnt - s0);
    end
    checks++;
    if (last_start_cyc != last_hs_cyc + 1) begin
      failures++;
      $display("FAIL single_start_timing: got cycle %0d required %0d", last_start_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_conflict();
    int g0, h0, o0, first_cyc;
    logic [3:0] got_g, exp_g;
    do_reset(2);
    g0 = grant_q.size();
    h0 = hs_cnt;
    o0 = out_cnt;
    first_cyc = 0;
    req0_dividend = rnd_op(); req0_divisor = rnd_div(); req0_id = 4'd4;
    req1_dividend = rnd_op(); req1_divisor = rnd_div(); req1_id = 4'd5;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_hs(h0 + k + 1);
      if (k == 0) first_cyc = last_hs_cyc;
      req0_dividend = rnd_op(); req0_divisor = rnd_div(); req0_id = IW'(k + 8);
      req1_dividend = rnd_op(); req1_divisor = rnd_div(); req1_id = IW'(k + 12);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_out(o0 + 4);
    got_g = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_q.size() > g0 + k) got_g[k] = (grant_q[g0 + k] == 1);
    end
`ifdef FP_DIV_SCHED_RR_EN
    exp_g = 4'b1010;
`else
    exp_g = 4'b0000;
`endif
    checks++;
    if (got_g !== exp_g) begin
      failures++;
      $display("FAIL conflict_grant_order: got %b required %b (bit k = port of grant k)", got_g, exp_g);
    end
    checks++;
    if (last_hs_cyc - first_cyc != 3 * (CORE_LAT + 2)) begin
      failures++;
      $display("FAIL back_to_back_spacing: got %0d cycles required %0d",
               last_hs_cyc - first_cyc, 3 * (CORE_LAT + 2));
    end
  endtask

  task automatic test_backpressure();
    int h0, o0, s0, n, bad;
    logic [EW-1:0] snap;
    h0 = hs_cnt;
    o0 = out_cnt;
    req0_dividend = rnd_op(); req0_divisor = rnd_div(); req0_id = 4'd6;
    req0_valid = 1'b1;
    out_ready = 1'b0;
    wait_hs(h0 + 1);
    req0_valid = 1'b0;
    req1_dividend = rnd_op(); req1_divisor = rnd_div(); req1_id = 4'd9;
    req1_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    snap = {out_port, out_id, out_quotient, out_remainder};
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || req0_ready || req1_ready
          || ({out_port, out_id, out_quotient, out_remainder} !== snap)) bad++;
    end
    checks++;
    if (bad != 0 || start_cnt != s0 || hs_cnt != h0 + 1) begin
      failures++;
      $display("FAIL backpressure_hold: got %0d bad cycles, %0d starts, %0d accepts, required 0/0/0",
               bad, start_cnt - s0, hs_cnt - h0 - 1);
    end
    out_ready = 1'b1;
    tick();
    req1_valid = 1'b0;
    checks++;
    if (hs_cnt != h0 + 2 || grant_q[grant_q.size() - 1] != 1) begin
      failures++;
      $display("FAIL backpressure_same_cycle_accept: got %0d accepts required 1 from port 1", hs_cnt - h0 - 1);
    end
    tick();
    checks++;
    if (last_start_cyc != last_hs_cyc + 1) begin
      failures++;
      $display("FAIL backpressure_start_timing: got cycle %0d required %0d", last_start_cyc, last_hs_cyc + 1);
    end
    wait_out(o0 + 2);
  endtask

  task automatic test_reset_mid_busy();
    int h0, s0, d0, o0, n;
    h0 = hs_cnt;
    s0 = start_cnt;
    out_ready = 1'b1;
    req0_dividend = rnd_op(); req0_divisor = rnd_div(); req0_id = 4'd7;
    req0_valid = 1'b1;
    wait_hs(h0 + 1);
    req0_valid = 1'b0;
    n = 0;
    while (start_cnt == s0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    checks++;
    if (dbg_state_o !== 2'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy_state: got state=%0d out_valid=%b required 0/0", dbg_state_o, out_valid);
    end
    o0 = ov_cnt;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (ov_cnt != o0 || done_cnt != d0 + 1 || dbg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL stale_done_discard: got out_valid cycles=%0d stale dones=%0d err=%b required 0/1/0",
               ov_cnt - o0, done_cnt - d0, dbg_err_o);
    end
  endtask

  task automatic test_spurious_done();
    int o0;
    o0 = ov_cnt;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    tick();
    checks++;
    if (ov_cnt != o0 || dbg_err_o !== 1'b1) begin
      failures++;
      $display("FAIL spurious_done: got out_valid cycles=%0d err=%b required 0/1", ov_cnt - o0, dbg_err_o);
    end
    do_reset(1);
    checks++;
    if (dbg_err_o !== 1'b0) begin
      failures++;
      $display("FAIL error_clear_on_reset: got %b required 0", dbg_err_o);
    end
  endtask

  task automatic test_operand_hold();
    int h0, o0;
    logic [DW-1:0] fin;
    h0 = hs_cnt;
    o0 = out_cnt;
    out_ready = 1'b0;
    req1_dividend = rnd_op(); req1_divisor = rnd_div(); req1_id = 4'd10;
    req1_valid = 1'b1;
    wait_hs(h0 + 1);
    req1_valid = 1'b0;
    req0_divisor = rnd_div();
    req0_id = 4'd11;
    req0_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req0_dividend = rnd_op();
      tick();
    end
    checks++;
    if (hs_cnt != h0 + 1) begin
      failures++;
      $display("FAIL operand_hold_no_accept: got %0d extra accepts required 0", hs_cnt - h0 - 1);
    end
    fin = rnd_op();
    req0_dividend = fin;
    out_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    req0_dividend = ~fin;
    tick();
    checks++;
    if (start_div !== fin || hs_cnt != h0 + 2) begin
      failures++;
      $display("FAIL operand_hold_capture: got %h required %h", start_div, fin);
    end
    wait_out(o0 + 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spur_done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b1;
    req0_dividend = 55'd100; req0_divisor = 55'd7; req0_id = '0;
    req1_dividend = 55'd200; req1_divisor = 55'd9; req1_id = '0;
    test_reset();
    test_single_op();
    test_conflict();
    test_backpressure();
    test_reset_mid_busy();
    test_spurious_done();
    test_operand_hold();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d results outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
